divider_controller: RTL and testbench
=====================================

DIVIDER_CONTROLLER -- requirements
Module: divider_controller

Interface
REQ-001 The block SHALL have parameter ITER, default 6, meaning the number of quotient bits and division iterations.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: division request, sampled only in IDLE.
REQ-005 The block SHALL have port A_0, input, 1 bit: sign bit of the datapath A register.
REQ-006 The block SHALL have ports ldA, ldQ, ldD, output, 1 bit each: load enables for the A, Q and D registers.
REQ-007 The block SHALL have ports Ashl, Qshl, output, 1 bit each: shift-left enables for A and Q, with A shifting in Q MSB.
REQ-008 The block SHALL have port sel1, output, 1 bit: 0 selects A_BUS into A, 1 selects adder result.
REQ-009 The block SHALL have port sel2, output, 1 bit: 1 selects subtract (A-D), 0 selects add (A+D).
REQ-010 The block SHALL have port toggle, output, 1 bit: sets Q LSB to 1.
REQ-011 The block SHALL have port ready, output, 1 bit: high only in IDLE.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse when remainder and quotient are valid.

Function
REQ-013 All outputs SHALL be Moore outputs decoded from state only, 0 unless listed for the state.
REQ-014 State IDLE SHALL assert ready, go to LOAD when start=1, and otherwise stay in IDLE.
REQ-015 State LOAD SHALL assert ldA, ldQ and ldD with sel1=0, clear the iteration counter, and go to SHIFT.
REQ-016 State SHIFT SHALL assert Ashl and Qshl and go to SUB.
REQ-017 State SUB SHALL assert ldA, sel1=1 and sel2=1 (A<=A-D) and go to CHECK.
REQ-018 State CHECK SHALL go to RESTORE when A_0=1, else to SETQ.
REQ-019 State RESTORE SHALL assert ldA, sel1=1 and sel2=0 (A<=A+D), leaving Q LSB at 0.
REQ-020 State SETQ SHALL assert toggle (Q LSB<=1).
REQ-021 From RESTORE or SETQ, the block SHALL go to DONE when counter=ITER-1, else increment the counter and go to SHIFT.
REQ-022 State DONE SHALL assert done for exactly one cycle and then go to IDLE.
REQ-023 The iteration counter SHALL be clog2(ITER) bits wide, count 0..ITER-1 and never wrap inside a division.
REQ-024 Latency SHALL be fixed: done is high in the 2+4*ITER-th cycle after the edge sampling start (26 for ITER=6), regardless of the quotient bits.
REQ-025 The block SHALL ignore start outside IDLE; start held high SHALL begin a new division on the first IDLE cycle after DONE.
REQ-026 Divisor 0 SHALL get no special handling: every iteration takes SETQ, giving quotient all ones and remainder equal to the dividend.
REQ-027 The block SHALL never assert ldA together with Ashl, or ldQ together with Qshl.

Reset
REQ-028 While rst=1, the block SHALL force state IDLE and counter 0 asynchronously, with ready=1 and all other outputs 0.
REQ-029 Reset mid-division SHALL abort it with no done pulse, leaving datapath register contents undefined from the controller's view.
REQ-030 After rst falls, the first start SHALL begin a complete new division.

Structure
REQ-031 Package divider_pkg SHALL hold the state enumeration (IDLE, LOAD, SHIFT, SUB, CHECK, RESTORE, SETQ, DONE) and counter-width constant.
REQ-032 The iteration counter SHALL be sub-module iter_counter (clear, increment, terminal-count output); the FSM SHALL be in divider_controller.
REQ-033 The state register SHALL be the only always-on-clock process in divider_controller; next-state and output decode SHALL be combinational.

Verification
REQ-034 Controller plus datapath, dividend 45, divisor 7, A_BUS 0, start pulse -> done in 26th cycle; quotient 6, remainder 3.
REQ-035 Dividend 63, divisor 1 -> quotient 63, remainder 0; toggle asserted 6 times, RESTORE never entered.
REQ-036 Dividend 5, divisor 9 -> quotient 0, remainder 5; RESTORE entered 6 times.
REQ-037 Divisor 0, dividend 21 -> quotient 63, remainder 21; done at cycle 26.
REQ-038 rst pulsed in cycle 10 of a division -> immediate IDLE with ready=1 and no done; next division 45/7 -> 6 R 3.
REQ-039 start held high for 60 cycles -> two back-to-back divisions, done pulses 27 cycles apart, start ignored while busy.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared definitions for the restoring-divider controller: state encoding and
// iteration-counter sizing.
package divider_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        SUB,
        CHECK,
        RESTORE,
        SETQ,
        DONE
    } state_t;

    localparam int ITER_DEFAULT = 6;

    // A single-iteration divider still needs a one-bit counter to hold a value.
    function automatic int cnt_width(input int iter);
        return (iter > 1) ? $clog2(iter) : 1;
    endfunction

    localparam int CNT_W = cnt_width(ITER_DEFAULT);

endpackage

// File: rtl/iter_counter.sv
// Division iteration counter: synchronous clear, saturating increment and a
// terminal-count flag at LAST.
module iter_counter #(
    parameter int W    = 3,
    parameter int LAST = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         tc
);

    assign tc = (count == W'(LAST));

    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !tc) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/divider_controller.sv
// Moore FSM sequencing a restoring divider datapath: load, then ITER rounds of
// shift / subtract / check / restore-or-set-bit, then a one-cycle done pulse.
module divider_controller
    import divider_pkg::*;
#(
    parameter int ITER = ITER_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic A_0,
    output logic ldA,
    output logic ldQ,
    output logic ldD,
    output logic Ashl,
    output logic Qshl,
    output logic sel1,
    output logic sel2,
    output logic toggle,
    output logic ready,
    output logic done
);

    localparam int CW = cnt_width(ITER);

    state_t          state;
    state_t          next_state;
    logic            cnt_clr;
    logic            cnt_inc;
    logic            cnt_tc;
    logic [CW-1:0]   cnt;

    iter_counter #(
        .W    (CW),
        .LAST (ITER - 1)
    ) u_iter_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (cnt),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        next_state = state;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        ldA        = 1'b0;
        ldQ        = 1'b0;
        ldD        = 1'b0;
        Ashl       = 1'b0;
        Qshl       = 1'b0;
        sel1       = 1'b0;
        sel2       = 1'b0;
        toggle     = 1'b0;
        ready      = 1'b0;
        done       = 1'b0;

        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) next_state = LOAD;
            end
            LOAD: begin
                ldA        = 1'b1;
                ldQ        = 1'b1;
                ldD        = 1'b1;
                cnt_clr    = 1'b1;
                next_state = SHIFT;
            end
            SHIFT: begin
                Ashl       = 1'b1;
                Qshl       = 1'b1;
                next_state = SUB;
            end
            SUB: begin
                ldA        = 1'b1;
                sel1       = 1'b1;
                sel2       = 1'b1;
                next_state = CHECK;
            end
            CHECK: begin
                // A negative trial remainder means the quotient bit is 0.
                next_state = A_0 ? RESTORE : SETQ;
            end
            RESTORE, SETQ: begin
                if (state == RESTORE) begin
                    ldA  = 1'b1;
                    sel1 = 1'b1;
                end else begin
                    toggle = 1'b1;
                end
                if (cnt_tc) begin
                    next_state = DONE;
                end else begin
                    cnt_inc    = 1'b1;
                    next_state = SHIFT;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_divider_controller.sv
// Drives divider_controller with a behavioural restoring-divider datapath and
// compares quotient, remainder, latency and path counts against plain arithmetic.
module tb_divider_controller;

    localparam int ITER    = 6;
    localparam int EXP_LAT = 2 + 4 * ITER;
    localparam int MAXV    = (1 << ITER) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic A_0;
    logic ldA, ldQ, ldD, Ashl, Qshl, sel1, sel2, toggle, ready, done;

    int checks = 0;
    int errors = 0;

    logic [ITER-1:0] dividend_bus = '0;
    logic [ITER-1:0] divisor_bus  = '0;
    logic [ITER:0]   a_reg = '0;
    logic [ITER:0]   d_reg = '0;
    logic [ITER-1:0] q_reg = '0;

    divider_controller #(.ITER(ITER)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .A_0    (A_0),
        .ldA    (ldA),
        .ldQ    (ldQ),
        .ldD    (ldD),
        .Ashl   (Ashl),
        .Qshl   (Qshl),
        .sel1   (sel1),
        .sel2   (sel2),
        .toggle (toggle),
        .ready  (ready),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Datapath: A is one bit wider than Q so its MSB carries the sign; A_BUS is 0.
    assign A_0 = a_reg[ITER];

    always @(posedge clk) begin
        if (ldA)       a_reg <= sel1 ? (sel2 ? a_reg - d_reg : a_reg + d_reg) : '0;
        else if (Ashl) a_reg <= {a_reg[ITER-1:0], q_reg[ITER-1]};
        if (ldQ)         q_reg <= dividend_bus;
        else if (Qshl)   q_reg <= {q_reg[ITER-2:0], 1'b0};
        else if (toggle) q_reg[0] <= 1'b1;
        if (ldD)       d_reg <= {1'b0, divisor_bus};
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_quot(input int a, input int b);
        return (b == 0) ? MAXV : a / b;
    endfunction

    function automatic int exp_rem(input int a, input int b);
        return (b == 0) ? a : a % b;
    endfunction

    function automatic int popcount(input int v);
        int n = 0;
        for (int i = 0; i < ITER; i++) n += (v >> i) & 1;
        return n;
    endfunction

    function automatic int outs_vec();
        return {ldA, ldQ, ldD, Ashl, Qshl, sel1, sel2, toggle, done};
    endfunction

    // One complete division from a single start pulse.
    task automatic run_div(input int a, input int b, input string tag);
        int  cyc;
        int  tog = 0;
        int  rest = 0;
        int  bad = 0;
        bit  seen = 0;
        dividend_bus = ITER'(a);
        divisor_bus  = ITER'(b);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (cyc = 1; cyc <= 4 * EXP_LAT; cyc++) begin
            @(negedge clk);
            if ((ldA && Ashl) || (ldQ && Qshl)) bad++;
            if (toggle) tog++;
            if (ldA && sel1 && !sel2) rest++;
            if (done) begin
                seen = 1;
                break;
            end
        end
        check({tag, "_latency"}, seen ? cyc : -1, EXP_LAT);
        check({tag, "_quot"}, int'(q_reg), exp_quot(a, b));
        check({tag, "_rem"}, int'(a_reg[ITER-1:0]), exp_rem(a, b));
        check({tag, "_toggles"}, tog, popcount(exp_quot(a, b)));
        check({tag, "_restores"}, rest, ITER - popcount(exp_quot(a, b)));
        check({tag, "_en_conflict"}, bad, 0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, int'(done), 0);
        check({tag, "_ready_after"}, int'(ready), 1);
    endtask

    initial begin
        int pulses;
        int first_done;
        int second_done;
        int saw_done;

        // Reset state, held across a few edges.
        repeat (3) @(negedge clk);
        check("reset_ready", int'(ready), 1);
        check("reset_outs", outs_vec(), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", int'(ready), 1);
        check("idle_outs", outs_vec(), 0);

        run_div(45, 7, "d45_7");
        run_div(63, 1, "d63_1");
        run_div(5, 9, "d5_9");
        run_div(21, 0, "d21_0");
        run_div(0, 5, "d0_5");
        run_div(63, 63, "d63_63");

        // Reset in cycle 10 of a division aborts it immediately.
        dividend_bus = 6'd45;
        divisor_bus  = 6'd7;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        saw_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) saw_done++;
        end
        check("abort_busy", int'(ready), 0);
        rst = 1'b1;
        #1;
        check("abort_ready", int'(ready), 1);
        check("abort_outs", outs_vec(), 0);
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done++;
        end
        check("abort_no_done", saw_done, 0);
        rst = 1'b0;
        run_div(45, 7, "post_abort");

        // start held high: back-to-back divisions, start ignored while busy.
        dividend_bus = 6'd45;
        divisor_bus  = 6'd7;
        @(negedge clk);
        start = 1'b1;
        pulses = 0;
        first_done = -1;
        second_done = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                if (pulses == 1) first_done = c;
                if (pulses == 2) second_done = c;
                check("held_quot", int'(q_reg), 6);
                check("held_rem", int'(a_reg[ITER-1:0]), 3);
            end
        end
        start = 1'b0;
        check("held_pulses", pulses, 2);
        check("held_first", first_done, EXP_LAT);
        check("held_spacing", second_done - first_done, EXP_LAT + 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Randomised operands against plain integer division.
        for (int i = 0; i < 24; i++) begin
            run_div(int'($urandom_range(0, MAXV)), int'($urandom_range(0, MAXV)),
                    $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
